// File: rtl/param_counter_pkg.sv
`default_nettype none
// ============================================================================
// param_counter_pkg : shared output-code constants and step encoding
// Rev 1.0
// ============================================================================
package param_counter_pkg;

  localparam int MODE_BIN  = 0;
  localparam int MODE_GRAY = 1;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_LOAD = 2'd1,
    STEP_INC  = 2'd2,
    STEP_DEC  = 2'd3
  } step_e;

  // Bits needed to hold a popcount of a w-bit vector (0..w inclusive).
  function automatic int pop_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/param_counter_activity.sv
`default_nettype none
// ============================================================================
// param_counter_activity : saturating accumulator of output bit toggles
// Rev 1.0
// ============================================================================
module param_counter_activity
  import param_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ACT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] val_cur,
  input  logic [WIDTH-1:0] val_nxt,
  output logic [ACT_W-1:0] act_log,
  output logic             act_sat
);

  localparam int POP_W = pop_w(WIDTH);
  // One spare bit so an overflowing sum is visible before clipping.
  localparam int SUM_W = ((ACT_W > POP_W) ? ACT_W : POP_W) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACT_W{1'b1}});

  logic [WIDTH-1:0] toggles;
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] sum;
  logic [ACT_W-1:0] acc_d, acc_q;
  logic             sat_d, sat_q;

  always_comb begin
    toggles = val_cur ^ val_nxt;
    pop     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + POP_W'(toggles[i]);
    end
    sum   = SUM_W'(acc_q) + SUM_W'(pop);
    acc_d = acc_q;
    sat_d = sat_q;
    if (clr) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (sum > ACC_MAX) begin
      acc_d = {ACT_W{1'b1}};
      sat_d = 1'b1;
    end else begin
      acc_d = sum[ACT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign act_log = acc_q;
  assign act_sat = sat_q;

endmodule
`default_nettype wire

// File: rtl/param_counter.sv
`default_nettype none
// ============================================================================
// param_counter : modulo up/down counter, binary or Gray output, toggle log
// Rev 1.0
// ============================================================================
module param_counter
  import param_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int MODE    = 0,
  parameter int ACT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LD_VAL,
  input  logic             CLR_ACT,
  output logic [WIDTH-1:0] VAL,
  output logic             TC,
  output logic [ACT_W-1:0] LOG_SWITCHING,
  output logic             ACT_SAT
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("param_counter: WIDTH must be within 2..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("param_counter: MODULUS must be within 2..2**WIDTH");
  end
  if (MODE != MODE_BIN && MODE != MODE_GRAY) begin : g_bad_mode
    $error("param_counter: MODE must be 0 (binary) or 1 (Gray)");
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] b);
    if (MODE == MODE_GRAY) return b ^ (b >> 1);
    return b;
  endfunction

  step_e            step;
  logic [WIDTH-1:0] cnt_d, cnt_q;
  logic             tc_d, tc_q;
  logic [WIDTH-1:0] val_nxt;

  always_comb begin
    step = STEP_HOLD;
    if (LOAD)    step = STEP_LOAD;
    else if (CE) step = UP ? STEP_INC : STEP_DEC;

    cnt_d = cnt_q;
    tc_d  = 1'b0;
    unique case (step)
      STEP_LOAD: cnt_d = (LD_VAL > MAX_CNT) ? MAX_CNT : LD_VAL;
      STEP_INC: begin
        if (cnt_q == MAX_CNT) begin
          cnt_d = '0;
          tc_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      STEP_DEC: begin
        if (cnt_q == '0) begin
          cnt_d = MAX_CNT;
          tc_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
      default: ;
    endcase
    val_nxt = encode(cnt_d);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign VAL = encode(cnt_q);
  assign TC  = tc_q;

  param_counter_activity #(
    .WIDTH (WIDTH),
    .ACT_W (ACT_W)
  ) u_activity (
    .clk     (CLK),
    .rst_n   (RST),
    .clr     (CLR_ACT),
    .val_cur (VAL),
    .val_nxt (val_nxt),
    .act_log (LOG_SWITCHING),
    .act_sat (ACT_SAT)
  );

endmodule
`default_nettype wire

// File: tb/tb_param_counter.sv
`default_nettype none
// ============================================================================
// tb_param_counter : three configurations driven in lockstep against a model
// Rev 1.0
// ============================================================================
module tb_param_counter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CE = 1'b0, UP = 1'b0, LOAD = 1'b0, CLR_ACT = 1'b0;
  logic [3:0] LD_VAL = 4'd0;

  logic [3:0]  val_b, val_g, val_s;
  logic        tc_b, tc_g, tc_s;
  logic        sat_b, sat_g, sat_s;
  logic [15:0] log_b, log_g;
  logic [3:0]  log_s;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // 0: binary mod-10, 1: Gray mod-16, 2: binary mod-16 with 4-bit log
  param_counter #(.WIDTH(4), .MODULUS(10), .MODE(0), .ACT_W(16)) u_bin (
    .CLK(CLK), .RST(RST), .CE(CE), .UP(UP), .LOAD(LOAD), .LD_VAL(LD_VAL),
    .CLR_ACT(CLR_ACT), .VAL(val_b), .TC(tc_b), .LOG_SWITCHING(log_b), .ACT_SAT(sat_b));
  param_counter #(.WIDTH(4), .MODULUS(16), .MODE(1), .ACT_W(16)) u_gray (
    .CLK(CLK), .RST(RST), .CE(CE), .UP(UP), .LOAD(LOAD), .LD_VAL(LD_VAL),
    .CLR_ACT(CLR_ACT), .VAL(val_g), .TC(tc_g), .LOG_SWITCHING(log_g), .ACT_SAT(sat_g));
  param_counter #(.WIDTH(4), .MODULUS(16), .MODE(0), .ACT_W(4)) u_sat (
    .CLK(CLK), .RST(RST), .CE(CE), .UP(UP), .LOAD(LOAD), .LD_VAL(LD_VAL),
    .CLR_ACT(CLR_ACT), .VAL(val_s), .TC(tc_s), .LOG_SWITCHING(log_s), .ACT_SAT(sat_s));

  typedef struct { int cnt; int acc; bit sat; bit tc; } mstate_t;
  typedef struct { int inst; int val; int tc; int lg; int sat; } exp_t;
  typedef struct { bit ce; bit up; bit ld; int ldv; bit clr; int exp_val; int exp_tc; } vec_t;

  mstate_t m [3];
  exp_t    sb [$];
  vec_t    tv [$];

  function automatic int mod_of(input int i);  return (i == 0) ? 10 : 16; endfunction
  function automatic int mode_of(input int i); return (i == 1) ? 1 : 0;   endfunction
  function automatic int actw_of(input int i); return (i == 2) ? 4 : 16;  endfunction
  function automatic int code(input int c, input int md);
    return (md != 0) ? (c ^ (c >> 1)) : c;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input int i, input bit ce,
                                    input bit up, input bit ld, input int ldv, input bit clr);
    mstate_t n;
    int md, mx, sum;
    n  = s;
    md = mod_of(i);
    mx = (1 << actw_of(i)) - 1;
    n.tc = 1'b0;
    if (ld) n.cnt = (ldv >= md) ? md - 1 : ldv;
    else if (ce && up) begin
      if (s.cnt == md - 1) begin n.cnt = 0; n.tc = 1'b1; end
      else n.cnt = s.cnt + 1;
    end else if (ce) begin
      if (s.cnt == 0) begin n.cnt = md - 1; n.tc = 1'b1; end
      else n.cnt = s.cnt - 1;
    end
    sum = s.acc + $countones(code(n.cnt, mode_of(i)) ^ code(s.cnt, mode_of(i)));
    if (clr) begin n.acc = 0; n.sat = 1'b0; end
    else if (sum > mx) begin n.acc = mx; n.sat = 1'b1; end
    else n.acc = sum;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic read_dut(input int i, output logic [31:0] v, output logic [31:0] t,
                          output logic [31:0] l, output logic [31:0] s);
    case (i)
      0:       begin v = {28'd0, val_b}; t = {31'd0, tc_b}; l = {16'd0, log_b}; s = {31'd0, sat_b}; end
      1:       begin v = {28'd0, val_g}; t = {31'd0, tc_g}; l = {16'd0, log_g}; s = {31'd0, sat_g}; end
      default: begin v = {28'd0, val_s}; t = {31'd0, tc_s}; l = {28'd0, log_s}; s = {31'd0, sat_s}; end
    endcase
  endtask

  task automatic check_zero(input string tag);
    logic [31:0] v, t, l, s;
    for (int i = 0; i < 3; i++) begin
      read_dut(i, v, t, l, s);
      chk($sformatf("%s val[%0d]", tag, i), v, 0);
      chk($sformatf("%s tc[%0d]", tag, i), t, 0);
      chk($sformatf("%s log[%0d]", tag, i), l, 0);
      chk($sformatf("%s sat[%0d]", tag, i), s, 0);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m[i] = '{0, 0, 1'b0, 1'b0};
    sb.delete();
  endtask

  // Drive one cycle, queue the model's view, then score the DUT after the edge.
  task automatic step(input bit ce, input bit up, input bit ld, input int ldv, input bit clr);
    exp_t        e;
    logic [31:0] v, t, l, s;
    CE = ce; UP = up; LOAD = ld; LD_VAL = 4'(ldv); CLR_ACT = clr;
    for (int i = 0; i < 3; i++) begin
      m[i] = mstep(m[i], i, ce, up, ld, ldv, clr);
      sb.push_back('{i, code(m[i].cnt, mode_of(i)), int'(m[i].tc), m[i].acc, int'(m[i].sat)});
    end
    @(posedge CLK);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_dut(e.inst, v, t, l, s);
      chk($sformatf("sb val[%0d]", e.inst), v, e.val);
      chk($sformatf("sb tc[%0d]", e.inst), t, e.tc);
      chk($sformatf("sb log[%0d]", e.inst), l, e.lg);
      chk($sformatf("sb sat[%0d]", e.inst), s, e.sat);
    end
  endtask

  task automatic do_reset();
    CE = 1'b0; UP = 1'b0; LOAD = 1'b0; CLR_ACT = 1'b0; LD_VAL = 4'd0;
    RST = 1'b0;
    model_reset();
    #2;
    check_zero("reset");
    @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int k = 1; k <= 9; k++) tv.push_back('{1, 1, 0, 0, 0, k, 0});
    tv.push_back('{1, 1, 0, 0,  0, 0, 1});   // wrap 9 -> 0
    tv.push_back('{1, 1, 0, 0,  0, 1, 0});
    tv.push_back('{1, 0, 0, 0,  0, 0, 0});
    tv.push_back('{1, 0, 0, 0,  0, 9, 1});   // wrap 0 -> 9
    tv.push_back('{0, 1, 0, 0,  0, 9, 0});   // hold, UP ignored
    tv.push_back('{0, 0, 1, 3,  0, 3, 0});
    tv.push_back('{1, 1, 1, 15, 0, 9, 0});   // clamp, load beats CE, no TC
    tv.push_back('{1, 1, 0, 0,  0, 0, 1});
    tv.push_back('{0, 0, 1, 12, 1, 9, 0});
    tv.push_back('{1, 1, 0, 0,  1, 0, 1});

    #1;
    do_reset();
    foreach (tv[k]) begin
      step(tv[k].ce, tv[k].up, tv[k].ld, tv[k].ldv, tv[k].clr);
      chk($sformatf("tbl%0d val", k), {28'd0, val_b}, tv[k].exp_val);
      chk($sformatf("tbl%0d tc", k), {31'd0, tc_b}, tv[k].exp_tc);
    end

    // Gray down-wrap straight out of reset
    do_reset();
    step(1, 0, 0, 0, 0);
    chk("gray dn val", {28'd0, val_g}, 4'b1000);
    chk("gray dn tc", {31'd0, tc_g}, 1);
    chk("gray dn log", {16'd0, log_g}, 1);

    // Load clamp with CE also high
    do_reset();
    step(1, 1, 1, 13, 0);
    chk("clamp val", {28'd0, val_b}, 9);
    chk("clamp tc", {31'd0, tc_b}, 0);
    chk("clamp log", {16'd0, log_b}, 2);

    // Saturation of the 4-bit log, then clear
    do_reset();
    repeat (9) step(1, 1, 0, 0, 0);
    chk("sat log", {28'd0, log_s}, 15);
    chk("sat flag", {31'd0, sat_s}, 1);
    step(1, 1, 0, 0, 1);
    chk("clr log", {28'd0, log_s}, 0);
    chk("clr flag", {31'd0, sat_s}, 0);
    chk("clr val", {28'd0, val_s}, 10);
    step(1, 1, 0, 0, 0);
    chk("post clr val", {28'd0, val_s}, 11);
    chk("post clr log", {28'd0, log_s}, 1);

    // Async reset between edges at VAL = 6
    do_reset();
    repeat (6) step(1, 1, 0, 0, 0);
    chk("pre async val", {28'd0, val_b}, 6);
    #3;
    RST = 1'b0;
    model_reset();
    #1;
    check_zero("async");
    #1;
    RST = 1'b1;
    step(1, 1, 0, 0, 0);
    chk("post async val", {28'd0, val_b}, 1);
    repeat (9) step(1, 1, 0, 0, 0);
    chk("pending tc", {31'd0, tc_b}, 1);
    #2;
    RST = 1'b0;
    model_reset();
    #1;
    check_zero("tc drop");
    #1;
    RST = 1'b1;

    // CE high on every third cycle
    do_reset();
    for (int i = 0; i < 12; i++) step((i % 3) == 0, 1, 0, 0, 0);
    chk("ce3 val", {28'd0, val_b}, 4);
    chk("ce3 log", {16'd0, log_b}, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
